// File: rtl/rx_frame_ctrl_pkg.sv
// Shared definitions for the rx frame controller: FSM state encoding and default widths.
package rx_frame_ctrl_pkg;

   localparam int unsigned DEFAULT_DATA_W = 8;
   localparam int unsigned DEFAULT_DEPTH  = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_ACK     = 2'd2
   } state_t;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous show-ahead FIFO with extra-MSB pointers; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module rx_fifo
   import rx_frame_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W,
   parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic              full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              push;
   logic              pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = rd_en & ~empty;
   assign push    = wr_en & (~full | pop);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible between the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Sequences the UART receiver: captures each completed frame, acks it, buffers good frames.
// Define RX_ERR_CNT_EN to add the saturating error-frame counter and its err_cnt port.
module rx_frame_ctrl
   import rx_frame_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W,
   parameter int unsigned DEPTH  = DEFAULT_DEPTH
`ifdef RX_ERR_CNT_EN
  ,parameter int unsigned CNT_W  = 8
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] rx_po,
   input  logic              rx_ready,
   input  logic              rx_error,
   input  logic              rx_busy,
   output logic              rx_data_ack,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              fifo_full,
   output logic              busy,
   output logic              ovf,
   input  logic              ovf_clr
`ifdef RX_ERR_CNT_EN
  ,output logic [CNT_W-1:0]  err_cnt
`endif
);

   state_t state_q, state_d;
   logic   ack_q, ack_d;
   logic   ovf_q, ovf_d;
   logic   capture;
   logic   good_frame;
   logic   drop;
   logic   fifo_empty;

   assign capture    = (state_q == ST_CAPTURE);
   assign good_frame = capture & ~rx_error;
   // A full FIFO still accepts the frame when the host pops in the same cycle.
   assign drop       = good_frame & fifo_full & ~rd_en;

   rx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (good_frame),
      .wr_data (rx_po),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      unique case (state_q)
         ST_IDLE: begin
            if (rx_ready) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
         end
         ST_ACK: begin
            if (!rx_ready) begin
               state_d = ST_IDLE;
               ack_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ack_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      ovf_d = ovf_q;
      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef RX_ERR_CNT_EN
   logic [CNT_W-1:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (capture && rx_error && (err_q != {CNT_W{1'b1}})) err_d = err_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= '0;
      else     err_q <= err_d;
   end

   assign err_cnt = err_q;
`endif

   assign rx_data_ack = ack_q;
   assign ovf         = ovf_q;
   assign rd_valid    = ~fifo_empty;
   assign busy        = rx_busy | (state_q != ST_IDLE);

endmodule
